// File: rtl/chip8_ram_upload.sv
// chip8_ram_upload
// Upload-side responder for the hps_io ioctl channel. Each upload read strobe
// is served from Chip-8 RAM, with ioctl offset 0 mapped to BASE_ADDR. This is
// the reverse of the ROM download path. Offsets past the loaded program span
// return PAD_BYTE without touching RAM. ioctl_wait holds hps_io off while the
// RAM port is arbitrated and read.
module chip8_ram_upload #(
  parameter int unsigned BASE_ADDR   = 512,
  parameter int unsigned RAM_SIZE    = 4096,
  parameter int unsigned RAM_LATENCY = 1,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic [12:0] bytes_sent,
  output logic        upload_done,
  output logic        overrun
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_REQ   = 2'd1;
  localparam logic [1:0]  ST_DATA  = 2'd2;

  // Offsets below SPAN map into RAM; anything at or above SPAN is padding.
  localparam logic [24:0] SPAN     = 25'(RAM_SIZE - BASE_ADDR);
  localparam logic [11:0] BASE12   = 12'(BASE_ADDR);
  localparam logic [1:0]  LAT_LOAD = 2'(RAM_LATENCY - 1);
  localparam logic [12:0] SENT_MAX = 13'h1FFF;

  logic [1:0]  state_q,       state_d;
  logic [1:0]  lat_cnt_q,     lat_cnt_d;
  logic        mem_req_q,     mem_req_d;
  logic [11:0] mem_addr_q,    mem_addr_d;
  logic [7:0]  ioctl_din_q,   ioctl_din_d;
  logic [12:0] bytes_sent_q,  bytes_sent_d;
  logic        upload_done_q, upload_done_d;
  logic        overrun_q,     overrun_d;
  logic        upload_prev_q, upload_prev_d;

  logic        rd_accept_s;
  logic        in_range_s;
  logic        upload_rise_s;
  logic        upload_fall_s;
  logic        complete_s;

  // Request qualification and session edge detection.
  always_comb begin
    rd_accept_s   = ioctl_rd & ioctl_upload & (state_q == ST_IDLE);
    in_range_s    = (ioctl_addr < SPAN);
    upload_rise_s = ioctl_upload & ~upload_prev_q;
    upload_fall_s = ~ioctl_upload & upload_prev_q;
  end

  // Service FSM. It also computes the RAM port request, the returned byte and the session counters.
  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    ioctl_din_d   = ioctl_din_q;
    complete_s    = 1'b0;
    upload_prev_d = ioctl_upload;
    upload_done_d = upload_fall_s;

    case (state_q)
      ST_IDLE: begin
        if (rd_accept_s) begin
          if (in_range_s) begin
            // The 12-bit add cannot wrap for offsets inside the span.
            mem_addr_d = ioctl_addr[11:0] + BASE12;
            mem_req_d  = 1'b1;
            state_d    = ST_REQ;
          end else begin
            // Out-of-span reads finish in the strobe cycle with padding.
            ioctl_din_d = PAD_BYTE;
            complete_s  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (!ioctl_upload) begin
          // The session ended; drop the request before it is granted.
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (mem_req_q && mem_gnt) begin
          mem_req_d = 1'b0;
          lat_cnt_d = LAT_LOAD;
          state_d   = ST_DATA;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_DATA: begin
        if (!ioctl_upload) begin
          // Discard the in-flight byte; din and the byte count stay as they are.
          lat_cnt_d = 2'd0;
          state_d   = ST_IDLE;
        end else if (lat_cnt_q == 2'd0) begin
          ioctl_din_d = mem_data;
          complete_s  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        lat_cnt_d = 2'd0;
      end
    endcase

    // A new session restarts the count. The count saturates rather than wrapping.
    if (upload_rise_s) begin
      bytes_sent_d = 13'd0;
    end else begin
      bytes_sent_d = bytes_sent_q;
    end
    if (complete_s && (bytes_sent_d != SENT_MAX)) begin
      bytes_sent_d = bytes_sent_d + 13'd1;
    end else begin
      bytes_sent_d = bytes_sent_d;
    end

    // A strobe while busy is lost. The flag stays set until the next session.
    if (ioctl_rd && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end else if (upload_rise_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      lat_cnt_q     <= 2'd0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 12'd0;
      ioctl_din_q   <= 8'd0;
      bytes_sent_q  <= 13'd0;
      upload_done_q <= 1'b0;
      overrun_q     <= 1'b0;
      upload_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      ioctl_din_q   <= ioctl_din_d;
      bytes_sent_q  <= bytes_sent_d;
      upload_done_q <= upload_done_d;
      overrun_q     <= overrun_d;
      upload_prev_q <= upload_prev_d;
    end
  end

  // Wait is raised in the strobe cycle itself, so hps_io never misses the hold-off.
  always_comb begin
    ioctl_wait = (state_q != ST_IDLE) | rd_accept_s;
  end

  assign ioctl_din   = ioctl_din_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign bytes_sent  = bytes_sent_q;
  assign upload_done = upload_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_chip8_ram_upload.sv
// Testbench for chip8_ram_upload: a RAM responder plus a byte/timing model built from the upload rules.
module tb_chip8_ram_upload;

  localparam int LAT  = 3;
  localparam int BASE = 512;
  localparam int SPAN = 3584;

  logic        clk_sys      = 1'b0;
  logic        reset_n      = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd     = 1'b0;
  logic [24:0] ioctl_addr   = 25'd0;
  logic        mem_gnt      = 1'b0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic [12:0] bytes_sent;
  logic        upload_done;
  logic        overrun;

  logic [7:0]        ram [0:4095];
  logic [2:0]        pipe_v    = 3'b000;
  logic [2:0][11:0]  pipe_addr = '0;
  logic [7:0]        junk_q    = 8'h00;
  int acc_count  = 0;
  int done_count = 0;
  int n_cmp      = 0;
  int n_fail     = 0;
  int exp_sent   = 0;
  logic [7:0] exp_din = 8'h00;

  always #10 clk_sys = ~clk_sys;

  chip8_ram_upload #(
    .BASE_ADDR(512), .RAM_SIZE(4096), .RAM_LATENCY(LAT), .PAD_BYTE(8'h00)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_data(mem_data), .bytes_sent(bytes_sent),
    .upload_done(upload_done), .overrun(overrun)
  );

  // RAM responder: data is valid LAT cycles after an accepted request, garbage otherwise.
  always @(posedge clk_sys) begin
    pipe_v    <= {pipe_v[1:0], mem_req & mem_gnt};
    pipe_addr <= {pipe_addr[1:0], mem_addr};
    junk_q    <= 8'($urandom);
    if (mem_req && mem_gnt) acc_count <= acc_count + 1;
    if (upload_done) done_count <= done_count + 1;
  end
  assign mem_data = pipe_v[LAT-1] ? ram[pipe_addr[LAT-1]] : junk_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One upload read, with an optional extra strobe injected at cycle inj (0 = none).
  task automatic do_read(input logic [24:0] addr, input int stall, input int inj);
    int cyc;
    int exp_cyc;
    int acc0;
    logic inr;
    logic [11:0] ea;
    inr     = (addr < 25'(SPAN));
    ea      = addr[11:0] + 12'(BASE);
    exp_cyc = inr ? (2 + stall + LAT) : 1;
    acc0    = acc_count;
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    mem_gnt    = 1'b0;
    #1 check("wait_on_strobe", 32'(ioctl_wait), 32'd1);
    cyc = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk_sys);
      cyc++;
      ioctl_rd = (cyc == inj) ? 1'b1 : 1'b0;
      mem_gnt  = (cyc > stall) ? 1'b1 : 1'b0;
      #1;
      if (!ioctl_wait) break;
      if (inr && cyc <= stall + 1) begin
        check("req_held", 32'(mem_req), 32'd1);
        check("req_addr", 32'(mem_addr), 32'(ea));
      end
    end
    ioctl_rd = 1'b0;
    mem_gnt  = 1'b0;
    check("wait_low_cycle", 32'(cyc), 32'(exp_cyc));
    exp_din = inr ? ram[ea] : 8'h00;
    if (exp_sent < 8191) exp_sent++;
    check("din", 32'(ioctl_din), 32'(exp_din));
    check("bytes_sent", 32'(bytes_sent), 32'(exp_sent));
    check("req_idle", 32'(mem_req), 32'd0);
    check("ram_accesses", 32'(acc_count - acc0), inr ? 32'd1 : 32'd0);
  endtask

  initial begin
    int acc0;
    int done0;
    logic [24:0] a;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[512] = 8'hA5;

    // Reset values
    repeat (3) @(negedge clk_sys);
    #1;
    check("rst_din", 32'(ioctl_din), 32'd0);
    check("rst_wait", 32'(ioctl_wait), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_sent", 32'(bytes_sent), 32'd0);
    check("rst_done", 32'(upload_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk_sys) reset_n = 1'b1;

    // A strobe outside an upload session is ignored
    @(negedge clk_sys) ioctl_rd = 1'b1;
    #1 check("no_session_wait", 32'(ioctl_wait), 32'd0);
    @(negedge clk_sys) ioctl_rd = 1'b0;
    #1 check("no_session_req", 32'(mem_req), 32'd0);
    check("no_session_sent", 32'(bytes_sent), 32'd0);

    @(negedge clk_sys) ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Directed reads: base byte, stalled grant, padding, span boundary
    do_read(25'd0, 0, 0);
    check("first_byte", 32'(ioctl_din), 32'hA5);
    do_read(25'h10, 5, 0);
    do_read(25'd3584, 0, 0);
    do_read(25'h1FFFFFF, 0, 0);
    do_read(25'd3583, 1, 0);
    for (int i = 0; i < 24; i++) do_read(25'($urandom_range(3999)), int'($urandom_range(3)), 0);

    // Strobe while busy: lost and flagged; a new session clears the flag
    check("overrun_clear", 32'(overrun), 32'd0);
    do_read(25'd5, 3, 2);
    check("overrun_set", 32'(overrun), 32'd1);
    done0 = done_count;
    @(negedge clk_sys) ioctl_upload = 1'b0;
    @(negedge clk_sys);
    #1 check("done_pulse", 32'(upload_done), 32'd1);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    #1 check("done_single", 32'(upload_done), 32'd0);
    check("overrun_rise_clr", 32'(overrun), 32'd0);
    check("sent_rise_clr", 32'(bytes_sent), 32'd0);
    check("done_count", 32'(done_count - done0), 32'd1);
    exp_sent = 0;

    // Session ends while the read is in its data phase
    do_read(25'($urandom_range(3583)), 0, 0);
    do_read(25'($urandom_range(3583)), 1, 0);
    a = 25'($urandom_range(3583));
    acc0  = acc_count;
    done0 = done_count;
    @(negedge clk_sys) begin ioctl_addr = a; ioctl_rd = 1'b1; mem_gnt = 1'b0; end
    @(negedge clk_sys) begin ioctl_rd = 1'b0; mem_gnt = 1'b1; end
    @(negedge clk_sys) mem_gnt = 1'b0;
    #1 check("data_busy", 32'(ioctl_wait), 32'd1);
    @(negedge clk_sys) ioctl_upload = 1'b0;
    @(negedge clk_sys);
    #1 check("abort_wait", 32'(ioctl_wait), 32'd0);
    check("abort_din", 32'(ioctl_din), 32'(exp_din));
    check("abort_sent", 32'(bytes_sent), 32'(exp_sent));
    check("abort_done_hi", 32'(upload_done), 32'd1);
    @(negedge clk_sys);
    #1 check("abort_done_lo", 32'(upload_done), 32'd0);
    check("abort_din_late", 32'(ioctl_din), 32'(exp_din));
    check("abort_acc", 32'(acc_count - acc0), 32'd1);
    check("abort_done_cnt", 32'(done_count - done0), 32'd1);

    // Session ends while the request is waiting for a grant
    @(negedge clk_sys) ioctl_upload = 1'b1;
    acc0 = acc_count;
    @(negedge clk_sys) begin ioctl_addr = 25'd20; ioctl_rd = 1'b1; mem_gnt = 1'b0; end
    @(negedge clk_sys) ioctl_rd = 1'b0;
    #1 check("req_pending", 32'(mem_req), 32'd1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    #1 check("abort_req_drop", 32'(mem_req), 32'd0);
    check("abort_req_wait", 32'(ioctl_wait), 32'd0);
    mem_gnt = 1'b1;
    @(negedge clk_sys);
    #1 check("abort_req_acc", 32'(acc_count - acc0), 32'd0);
    mem_gnt = 1'b0;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    exp_sent = 0;

    // Full sequential upload of an incrementing pattern
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i);
    done0 = done_count;
    for (int i = 0; i < SPAN; i++) do_read(25'(i), int'($urandom_range(1)), 0);
    check("seq_sent", 32'(bytes_sent), 32'd3584);
    @(negedge clk_sys) ioctl_upload = 1'b0;
    repeat (3) @(negedge clk_sys);
    #1 check("seq_done", 32'(done_count - done0), 32'd1);
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    exp_sent = 0;

    // Byte count saturation with padding reads
    for (int i = 0; i < 8192; i++) do_read(25'($urandom_range(33554431, 3584)), 0, 0);
    check("sent_saturated", 32'(bytes_sent), 32'd8191);

    // Reset in the middle of a request
    @(negedge clk_sys) begin ioctl_addr = 25'd7; ioctl_rd = 1'b1; mem_gnt = 1'b0; end
    @(negedge clk_sys) ioctl_rd = 1'b0;
    #1 check("pre_reset_req", 32'(mem_req), 32'd1);
    @(negedge clk_sys) reset_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_wait", 32'(ioctl_wait), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_din", 32'(ioctl_din), 32'd0);
    check("mid_rst_sent", 32'(bytes_sent), 32'd0);
    acc0 = acc_count;
    @(negedge clk_sys) begin reset_n = 1'b1; mem_gnt = 1'b1; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      #1 check("post_rst_no_req", 32'(mem_req), 32'd0);
    end
    check("post_rst_acc", 32'(acc_count - acc0), 32'd0);
    mem_gnt  = 1'b0;
    exp_sent = 0;
    exp_din  = 8'h00;
    do_read(25'($urandom_range(3583)), 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chip8_ram_upload.md
Name: chip8_ram_upload

Overview:
- Upload-side responder for the HPS ioctl channel. It serves hps_io upload read requests by fetching bytes from Chip-8 RAM, starting at program base 0x200.
- It is the reverse path of the ROM download, which writes ioctl_addr+512 into RAM.
- It sits between hps_io and the Chip-8 RAM arbitration port, in the clk_sys domain.
- It holds hps_io off with ioctl_wait while RAM is arbitrated and read.

Parameters:
- BASE_ADDR, 512: RAM address that corresponds to ioctl_addr 0.
- RAM_SIZE, 4096: RAM depth in bytes. Valid upload span is RAM_SIZE-BASE_ADDR bytes.
- RAM_LATENCY, 1: cycles from the accepted request (mem_req&mem_gnt) to mem_data valid. Legal range 1..3.
- PAD_BYTE, 8'h00: value returned for addresses beyond the valid span.

Ports:
- clk_sys  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_upload  in  1  high for the whole upload session.
- ioctl_rd  in  1  one-cycle read strobe.
- ioctl_addr  in  25  byte offset of the request.
- ioctl_din  out  8  returned byte.
- ioctl_wait  out  1  high while a request is in service.
- mem_req  out  1  RAM read request. Held until granted.
- mem_gnt  in  1  arbiter grant.
- mem_addr  out  12  RAM byte address.
- mem_data  in  8  RAM read data.
- bytes_sent  out  13  count of bytes completed this session.
- upload_done  out  1  one-cycle pulse at the end of the session.
- overrun  out  1  sticky flag: ioctl_rd arrived while busy.

Behaviour:
- Reset values (async on reset_n low): all outputs 0; state IDLE; internal registers 0.
- ioctl_wait = (state!=IDLE) | (ioctl_rd & ioctl_upload & state==IDLE). hps_io therefore sees wait in the same cycle as the strobe.
- States: IDLE, REQ, DATA.
- IDLE:
  - On ioctl_rd & ioctl_upload, latch off = ioctl_addr.
  - If off < RAM_SIZE-BASE_ADDR: mem_addr <= off[11:0]+BASE_ADDR (12-bit add; wrap is impossible in range), mem_req <= 1, go to REQ.
  - Otherwise: ioctl_din <= PAD_BYTE, bytes_sent++, stay in IDLE. This is a one-cycle service; wait drops the next cycle.
  - ioctl_rd with ioctl_upload low is ignored and wait stays low.
- REQ:
  - Hold mem_req and mem_addr stable until mem_gnt.
  - On the cycle with mem_req&mem_gnt: mem_req <= 0, load the latency counter with RAM_LATENCY-1, go to DATA.
- DATA:
  - When the counter reaches 0, capture ioctl_din <= mem_data, bytes_sent++, go to IDLE. ioctl_wait is low from the next cycle.
  - Uncontended latency from ioctl_rd to wait low: 2+RAM_LATENCY cycles.
- ioctl_din holds its value until the next completion.
- ioctl_rd while state!=IDLE: the request is not served and overrun <= 1. overrun clears only on the rising edge of ioctl_upload or on reset.
- Session edges:
  - Rising edge of ioctl_upload: bytes_sent <= 0, overrun <= 0.
  - Falling edge of ioctl_upload: upload_done pulses high for one cycle.
- ioctl_upload falling mid-operation:
  - Abort to IDLE in the next cycle; mem_req drops immediately, registered.
  - Data for the in-flight read is discarded; bytes_sent and ioctl_din are not updated.
  - upload_done still pulses.
- mem_gnt is ignored when mem_req is low.
- bytes_sent saturates at 8191.
- reset_n asserted mid-operation: everything returns to reset values immediately. No memory access is issued after release until a new ioctl_rd arrives.

Test Plan:
- RAM_LATENCY=1, mem_gnt tied 1, ioctl_upload=1, ioctl_rd at addr 0, RAM[0x200]=0xA5 -> mem_addr=0x200 and mem_req high cycle 1; ioctl_din=0xA5 and wait low at cycle 3; bytes_sent=1.
- mem_gnt held low 5 cycles, addr 0x10 -> mem_req and mem_addr=0x210 stable throughout; data captured RAM_LATENCY cycles after grant; wait high for all 5 stall cycles plus service time.
- ioctl_rd at addr 3584 and at addr 0x1FFFFFF -> no mem_req; ioctl_din=0x00 next cycle; wait high only in the strobe cycle; bytes_sent increments twice.
- Second ioctl_rd while in REQ -> overrun=1 and only one mem_req transaction. Toggle ioctl_upload 0->1 -> overrun=0, bytes_sent=0.
- Drop ioctl_upload during DATA with RAM_LATENCY=3 -> state IDLE next cycle; ioctl_din unchanged; bytes_sent unchanged; upload_done one-cycle pulse.
- Sequential upload of 3584 bytes with incrementing RAM pattern -> every ioctl_din equals RAM[addr+0x200]; bytes_sent=3584; single upload_done at end.
